fcvt_f2i: RTL and testbench

//  FP32 -> integer converter (FCVT.W.S / FCVT.WU.S) for the floating ALU F_CVT path; inverse of the
//  int->float normalising converter. 2-stage valid/ready pipeline: stage 1 unpacks and aligns,

---
 rtl/fcvt_pkg.sv | 47 ++++
 rtl/fcvt_rshift_sticky.sv | 35 +++
 rtl/fcvt_f2i.sv | 194 +++++++++++++++++++
 tb/tb_fcvt_f2i.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fcvt_pkg.sv
// Shared encodings and helpers for the FP32 -> int32/uint32 converter.
// Unsigned conversion is present only when FCVT_WU_EN is defined.
package fcvt_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_BIAS  = 127;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rm_e;

  localparam int FFLAG_NV = 4;
  localparam int FFLAG_NX = 0;

  localparam logic [31:0] INT32_MAX  = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN  = 32'h8000_0000;
  localparam logic [31:0] UINT32_MAX = 32'hFFFF_FFFF;

  // Aligned operand held between the align and round stages.
  typedef struct packed {
    logic        sign;
    logic        nan;
    logic        ovf;
    logic [2:0]  rm;
    logic [31:0] mag;
    logic        g;
    logic        s;
  } s1_t;

  // Reserved rounding modes fall through to truncation.
  function automatic logic round_inc(input logic [2:0] mode, input logic sign,
                                     input logic g, input logic s, input logic lsb);
    case (mode)
      RM_RNE:  return g & (s | lsb);
      RM_RDN:  return sign & (g | s);
      RM_RUP:  return ~sign & (g | s);
      RM_RMM:  return g;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fcvt_rshift_sticky.sv
// Aligns a 24-bit significand by its unbiased exponent into a 32-bit integer
// plus guard and sticky bits for the rounding stage.
module fcvt_rshift_sticky (
  input  logic        [23:0] sig,
  input  logic signed [9:0]  e,
  output logic        [31:0] int_part,
  output logic               guard,
  output logic               sticky
);

  logic [63:0] base;
  logic [63:0] fx;

  // Fixed point: [63:32] integer, [31:0] fraction; sig starts as 1.xxx at bit 32.
  always_comb begin
    base     = {31'd0, sig, 9'd0};
    fx       = '0;
    int_part = '0;
    guard    = 1'b0;
    sticky   = 1'b0;
    if (e >= 10'sd0 && e <= 10'sd31) begin
      fx = base << e[4:0];
    end else if (e == -10'sd1) begin
      fx = base >> 1;
    end
    if (e < -10'sd1) begin
      sticky = |sig;
    end else if (e <= 10'sd31) begin
      int_part = fx[63:32];
      guard    = fx[31];
      sticky   = |fx[30:0];
    end
  end

endmodule

// File: rtl/fcvt_f2i.sv
// FP32 -> integer converter (FCVT.W.S / FCVT.WU.S), two-stage valid/ready pipeline.
// Define FCVT_WU_EN to honour is_unsigned; otherwise every op converts as signed.
module fcvt_f2i
  import fcvt_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      rs1,
  input  logic [2:0]       rm,
  input  logic             is_unsigned,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      result,
  output logic [4:0]       fflags,
  output logic [TAG_W-1:0] out_tag
);

  logic                in_sign;
  logic [FP_EXP_W-1:0] in_exp;
  logic [FP_MAN_W-1:0] in_man;
  logic signed [9:0]   in_e;
  logic [23:0]         in_sig;
  logic [31:0]         al_int;
  logic                al_g;
  logic                al_s;
  logic                op_unsigned;
  logic                in_ovf;
  s1_t                 s1_d;

  logic                s1_v;
  s1_t                 s1;
  logic [TAG_W-1:0]    s1_tag;
  logic                s1_adv;

  logic                inc;
  logic [32:0]         mag;
  logic                inexact;
  logic [31:0]         sres;
  logic                snv;
  logic [31:0]         res_d;
  logic                nv_d;
  logic                nx_d;
  logic [4:0]          flags_d;

  assign in_sign = rs1[31];
  assign in_exp  = rs1[30:23];
  assign in_man  = rs1[22:0];
  assign in_e    = $signed({2'b00, in_exp}) - 10'sd127;
  assign in_sig  = {|in_exp, in_man};

`ifdef FCVT_WU_EN
  assign op_unsigned = is_unsigned;
`else
  logic unused_is_unsigned;
  assign unused_is_unsigned = is_unsigned;
  assign op_unsigned        = 1'b0;
`endif

  fcvt_rshift_sticky u_align (
    .sig      (in_sig),
    .e        (in_e),
    .int_part (al_int),
    .guard    (al_g),
    .sticky   (al_s)
  );

  // -2^31 is the only signed value with exponent 31 that still fits.
  assign in_ovf = (in_e > 10'sd31) |
                  (~op_unsigned & (in_e == 10'sd31) & ~(in_sign & (in_man == '0)));

  always_comb begin
    s1_d      = '0;
    s1_d.sign = in_sign;
    s1_d.nan  = (&in_exp) & (|in_man);
    s1_d.ovf  = in_ovf;
    s1_d.rm   = rm;
    s1_d.mag  = al_int;
    s1_d.g    = al_g;
    s1_d.s    = al_s;
  end

  assign s1_adv   = ~out_valid | out_ready;
  assign in_ready = ~flush & (~s1_v | s1_adv);

  assign inc     = round_inc(s1.rm, s1.sign, s1.g, s1.s, s1.mag[0]);
  assign mag     = {1'b0, s1.mag} + {32'd0, inc};
  assign inexact = s1.g | s1.s;

  // Signed result: infinities land in the ovf path and saturate by sign.
  always_comb begin
    sres = '0;
    snv  = 1'b0;
    if (s1.nan) begin
      sres = INT32_MAX;
      snv  = 1'b1;
    end else if (s1.ovf) begin
      sres = s1.sign ? INT32_MIN : INT32_MAX;
      snv  = 1'b1;
    end else if (!s1.sign && mag > {1'b0, INT32_MAX}) begin
      sres = INT32_MAX;
      snv  = 1'b1;
    end else if (s1.sign && mag > {1'b0, INT32_MIN}) begin
      sres = INT32_MIN;
      snv  = 1'b1;
    end else begin
      sres = s1.sign ? (~mag[31:0] + 32'd1) : mag[31:0];
    end
  end

`ifdef FCVT_WU_EN
  logic        s1_uns;
  logic [31:0] ures;
  logic        unv;

  // Negative inputs clamp to zero; only a nonzero rounded magnitude is invalid.
  always_comb begin
    ures = '0;
    unv  = 1'b0;
    if (s1.nan) begin
      ures = UINT32_MAX;
      unv  = 1'b1;
    end else if (s1.sign) begin
      ures = '0;
      unv  = s1.ovf | (mag != '0);
    end else if (s1.ovf || mag[32]) begin
      ures = UINT32_MAX;
      unv  = 1'b1;
    end else begin
      ures = mag[31:0];
    end
  end

  assign res_d = s1_uns ? ures : sres;
  assign nv_d  = s1_uns ? unv  : snv;

  always_ff @(posedge CLK) begin
    if (rst) begin
      s1_uns <= 1'b0;
    end else if (!flush && in_ready && in_valid) begin
      s1_uns <= is_unsigned;
    end
  end
`else
  assign res_d = sres;
  assign nv_d  = snv;
`endif

  assign nx_d = inexact & ~nv_d;

  always_comb begin
    flags_d           = '0;
    flags_d[FFLAG_NV] = nv_d;
    flags_d[FFLAG_NX] = nx_d;
  end

  // Stage 2 loads whenever the output slot frees; stage 1 refills behind it.
  always_ff @(posedge CLK) begin
    if (rst) begin
      s1_v      <= 1'b0;
      s1        <= '0;
      s1_tag    <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      fflags    <= '0;
      out_tag   <= '0;
    end else if (flush) begin
      s1_v      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (s1_adv) begin
        out_valid <= s1_v;
        if (s1_v) begin
          result  <= res_d;
          fflags  <= flags_d;
          out_tag <= s1_tag;
        end
      end
      if (in_ready) begin
        s1_v <= in_valid;
        if (in_valid) begin
          s1     <= s1_d;
          s1_tag <= in_tag;
        end
      end
    end
  end

endmodule

// File: tb/tb_fcvt_f2i.sv
// Directed self-checking bench for fcvt_f2i; expectations follow FCVT_WU_EN
// when it is defined for the build.
module tb_fcvt_f2i;
  import fcvt_pkg::*;

  localparam int TAG_W = 5;

  logic             CLK = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      rs1;
  logic [2:0]       rm;
  logic             is_unsigned;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      result;
  logic [4:0]       fflags;
  logic [TAG_W-1:0] out_tag;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  fcvt_f2i #(.TAG_W(TAG_W)) dut (
    .CLK         (CLK),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .rs1         (rs1),
    .rm          (rm),
    .is_unsigned (is_unsigned),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .fflags      (fflags),
    .out_tag     (out_tag)
  );

  // Sends one op and samples the output exactly two edges after acceptance.
  task automatic applyStimulus(input logic [31:0] a, input logic [2:0] r, input logic u,
                               input logic [TAG_W-1:0] t, output logic ok,
                               output logic [31:0] res, output logic [4:0] flg,
                               output logic [TAG_W-1:0] tg);
    int waitc;
    ok = 1'b0; res = '0; flg = '0; tg = '0;
    @(negedge CLK);
    rs1 = a; rm = r; is_unsigned = u; in_tag = t; in_valid = 1'b1; out_ready = 1'b1;
    waitc = 0;
    while (!in_ready && waitc < 20) begin
      @(negedge CLK);
      waitc++;
    end
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    @(posedge CLK);
    @(negedge CLK);
    in_valid = 1'b0;
    if (out_valid) return;
    @(posedge CLK);
    @(negedge CLK);
    ok = out_valid; res = result; flg = fflags; tg = out_tag;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    rs1 = '0; rm = '0; is_unsigned = 1'b0; in_tag = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (result !== 32'h0) begin n_bad++; $display("[TB] FAIL reset result: got %h expected 0", result); end
    n_cmp++; if (fflags !== 5'h0) begin n_bad++; $display("[TB] FAIL reset fflags: got %h expected 0", fflags); end
    n_cmp++; if (out_tag !== '0) begin n_bad++; $display("[TB] FAIL reset out_tag: got %h expected 0", out_tag); end
    rst = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL reset in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_rounding();
    logic [31:0] ta [10];
    logic [2:0]  tr [10];
    logic [31:0] te [10];
    logic [4:0]  tf [10];
    logic ok; logic [31:0] res; logic [4:0] flg; logic [TAG_W-1:0] tg;
    ta = '{32'h40200000, 32'h40200000, 32'h40200000, 32'h40200000, 32'h40200000,
           32'hC0200000, 32'h40600000, 32'h3F000000, 32'h3F000000, 32'hC0200000};
    tr = '{RM_RNE, RM_RMM, RM_RUP, RM_RDN, 3'b101, RM_RDN, RM_RNE, RM_RNE, RM_RMM, RM_RTZ};
    te = '{32'd2, 32'd3, 32'd3, 32'd2, 32'd2, 32'hFFFFFFFD, 32'd4, 32'd0, 32'd1, 32'hFFFFFFFE};
    tf = '{5'h01, 5'h01, 5'h01, 5'h01, 5'h01, 5'h01, 5'h01, 5'h01, 5'h01, 5'h01};
    for (int i = 0; i < 10; i++) begin
      applyStimulus(ta[i], tr[i], 1'b0, TAG_W'(i), ok, res, flg, tg);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("[TB] FAIL round[%0d] latency: got valid=%b expected 1 two edges after accept", i, ok); end
      n_cmp++; if (res !== te[i]) begin n_bad++; $display("[TB] FAIL round[%0d] result: got %h expected %h", i, res, te[i]); end
      n_cmp++; if (flg !== tf[i]) begin n_bad++; $display("[TB] FAIL round[%0d] fflags: got %h expected %h", i, flg, tf[i]); end
      n_cmp++; if (tg !== TAG_W'(i)) begin n_bad++; $display("[TB] FAIL round[%0d] tag: got %h expected %h", i, tg, TAG_W'(i)); end
    end
  endtask

  task automatic test_saturation();
    logic [31:0] ta [8];
    logic [31:0] te [8];
    logic [4:0]  tf [8];
    logic ok; logic [31:0] res; logic [4:0] flg; logic [TAG_W-1:0] tg;
    ta = '{32'hCF000000, 32'h4F000000, 32'hFF800000, 32'h7F800000,
           32'hCF000001, 32'h4EFFFFFF, 32'h7FC00000, 32'h80000000};
    te = '{32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF,
           32'h80000000, 32'h7FFFFF80, 32'h7FFFFFFF, 32'h00000000};
    tf = '{5'h00, 5'h10, 5'h10, 5'h10, 5'h10, 5'h00, 5'h10, 5'h00};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(ta[i], RM_RTZ, 1'b0, TAG_W'(i + 10), ok, res, flg, tg);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("[TB] FAIL sat[%0d] latency: got valid=%b expected 1", i, ok); end
      n_cmp++; if (res !== te[i]) begin n_bad++; $display("[TB] FAIL sat[%0d] result: got %h expected %h", i, res, te[i]); end
      n_cmp++; if (flg !== tf[i]) begin n_bad++; $display("[TB] FAIL sat[%0d] fflags: got %h expected %h", i, flg, tf[i]); end
    end
  endtask

  task automatic test_unsigned();
    logic [31:0] ta [8];
    logic [2:0]  tr [8];
    logic [31:0] te [8];
    logic [4:0]  tf [8];
    logic ok; logic [31:0] res; logic [4:0] flg; logic [TAG_W-1:0] tg;
    ta = '{32'hBE99999A, 32'hBF800000, 32'h7FC00000, 32'h4F800000,
           32'h4F000000, 32'h80000000, 32'hBF000000, 32'hBF000000};
    tr = '{RM_RTZ, RM_RTZ, RM_RTZ, RM_RTZ, RM_RTZ, RM_RTZ, RM_RNE, RM_RMM};
`ifdef FCVT_WU_EN
    te = '{32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h0, 32'h0, 32'h0};
    tf = '{5'h01, 5'h10, 5'h10, 5'h10, 5'h00, 5'h00, 5'h01, 5'h10};
`else
    te = '{32'h0, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFF};
    tf = '{5'h01, 5'h00, 5'h10, 5'h10, 5'h10, 5'h00, 5'h01, 5'h01};
`endif
    for (int i = 0; i < 8; i++) begin
      applyStimulus(ta[i], tr[i], 1'b1, TAG_W'(i + 20), ok, res, flg, tg);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("[TB] FAIL uns[%0d] latency: got valid=%b expected 1", i, ok); end
      n_cmp++; if (res !== te[i]) begin n_bad++; $display("[TB] FAIL uns[%0d] result: got %h expected %h", i, res, te[i]); end
      n_cmp++; if (flg !== tf[i]) begin n_bad++; $display("[TB] FAIL uns[%0d] fflags: got %h expected %h", i, flg, tf[i]); end
    end
  endtask

  // Streams eight ops while the consumer stalls for three cycles.
  task automatic test_back_to_back();
    logic [31:0]      va [8];
    int               sent, rcv;
    logic             saw_drop, prev_stall;
    logic [31:0]      prev_res;
    logic [TAG_W-1:0] prev_tag;
    int               extra;
    va = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
           32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    sent = 0; rcv = 0; saw_drop = 1'b0; prev_stall = 1'b0; prev_res = '0; prev_tag = '0;
    rm = RM_RTZ; is_unsigned = 1'b0;
    for (int c = 0; c < 60 && rcv < 8; c++) begin
      @(negedge CLK);
      out_ready = !(c >= 4 && c < 7);
      in_valid  = (sent < 8);
      rs1       = (sent < 8) ? va[sent] : 32'h0;
      in_tag    = TAG_W'(sent + 16);
      #1;
      if (!in_ready) saw_drop = 1'b1;
      if (out_valid && out_ready) begin
        n_cmp++; if (result !== 32'(rcv + 1)) begin n_bad++; $display("[TB] FAIL b2b[%0d] result: got %h expected %h", rcv, result, 32'(rcv + 1)); end
        n_cmp++; if (out_tag !== TAG_W'(rcv + 16)) begin n_bad++; $display("[TB] FAIL b2b[%0d] tag: got %h expected %h", rcv, out_tag, TAG_W'(rcv + 16)); end
        rcv++;
      end
      if (out_valid && !out_ready) begin
        if (prev_stall) begin
          n_cmp++; if (result !== prev_res || out_tag !== prev_tag) begin n_bad++; $display("[TB] FAIL b2b stall hold: got %h/%h expected %h/%h", result, out_tag, prev_res, prev_tag); end
        end
        prev_stall = 1'b1; prev_res = result; prev_tag = out_tag;
      end else begin
        prev_stall = 1'b0;
      end
      if (in_valid && in_ready) sent++;
    end
    @(negedge CLK);
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++; if (rcv !== 8) begin n_bad++; $display("[TB] FAIL b2b count: got %0d expected 8", rcv); end
    n_cmp++; if (saw_drop !== 1'b1) begin n_bad++; $display("[TB] FAIL b2b in_ready drop: got %b expected 1", saw_drop); end
    extra = 0;
    repeat (3) begin
      @(negedge CLK);
      if (out_valid) extra++;
    end
    n_cmp++; if (extra !== 0) begin n_bad++; $display("[TB] FAIL b2b duplicate: got %0d extra results expected 0", extra); end
  endtask

  task automatic test_flush();
    int seen;
    @(negedge CLK);
    out_ready = 1'b0; in_valid = 1'b1; rs1 = 32'h3F800000; rm = RM_RTZ; is_unsigned = 1'b0; in_tag = 5'd1;
    @(posedge CLK);
    @(negedge CLK);
    rs1 = 32'h40000000; in_tag = 5'd2;
    @(posedge CLK);
    @(negedge CLK);
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL flush pre out_valid: got %b expected 1", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL flush pre in_ready: got %b expected 0", in_ready); end
    out_ready = 1'b1; flush = 1'b1; in_valid = 1'b1; rs1 = 32'h40400000; in_tag = 5'd3;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL flush in_ready: got %b expected 0", in_ready); end
    @(posedge CLK);
    @(negedge CLK);
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL flush out_valid: got %b expected 0", out_valid); end
    seen = 0;
    repeat (3) begin
      @(negedge CLK);
      if (out_valid) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("[TB] FAIL flush leak: got %0d results expected 0", seen); end
  endtask

  task automatic test_reset_midstream();
    int seen;
    logic ok; logic [31:0] res; logic [4:0] flg; logic [TAG_W-1:0] tg;
    @(negedge CLK);
    out_ready = 1'b1; in_valid = 1'b1; rs1 = 32'h40200000; rm = RM_RNE; is_unsigned = 1'b0; in_tag = 5'd9;
    @(posedge CLK);
    @(negedge CLK);
    rs1 = 32'h40600000; in_tag = 5'd10;
    @(posedge CLK);
    @(negedge CLK);
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || result !== 32'd2) begin n_bad++; $display("[TB] FAIL rst pre: got valid=%b result=%h expected 1/00000002", out_valid, result); end
    rst = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL rst out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (result !== 32'h0) begin n_bad++; $display("[TB] FAIL rst result: got %h expected 0", result); end
    n_cmp++; if (fflags !== 5'h0) begin n_bad++; $display("[TB] FAIL rst fflags: got %h expected 0", fflags); end
    n_cmp++; if (out_tag !== '0) begin n_bad++; $display("[TB] FAIL rst out_tag: got %h expected 0", out_tag); end
    rst = 1'b0;
    seen = 0;
    repeat (2) begin
      @(negedge CLK);
      if (out_valid) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("[TB] FAIL rst leak: got %0d results expected 0", seen); end
    applyStimulus(32'h00000001, RM_RUP, 1'b0, 5'd7, ok, res, flg, tg);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("[TB] FAIL denorm latency: got valid=%b expected 1", ok); end
    n_cmp++; if (res !== 32'd1) begin n_bad++; $display("[TB] FAIL denorm result: got %h expected 00000001", res); end
    n_cmp++; if (flg !== 5'h01) begin n_bad++; $display("[TB] FAIL denorm fflags: got %h expected 01", flg); end
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_saturation();
    test_unsigned();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
